// File: rtl/ram_out_bit_serializer_pkg.sv
// Shared defaults and FSM state encodings for the RAM-to-bit-stream serializer.
// Word/address widths match the byte RAM buffer in the BTLE TX path.
package ram_out_bit_serializer_pkg;

  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_ADDRESS_WIDTH    = 6;
  localparam int DEF_RAM_READ_LATENCY = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    SHIFT = ST_SHIFT
  } state_t;

endpackage

// File: rtl/ram_out_bit_serializer_bit_shift_out.sv
// Word-wide shift register with a bit counter; presents one bit at a time,
// LSB or MSB first, and flags the last bit of the loaded word.
module bit_shift_out #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  bit_cur,
  output logic                  last_bit
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  // Datapath register: no reset, the top gates the output with bit_valid
  always_ff @(posedge clk) begin
    if (load) begin
      shift_reg <= din;
    end else if (shift) begin
      shift_reg <= LSB_FIRST ? {1'b0, shift_reg[DATA_WIDTH-1:1]}
                             : {shift_reg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else if (shift) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign bit_cur  = LSB_FIRST ? shift_reg[0] : shift_reg[DATA_WIDTH-1];
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/ram_out_bit_serializer.sv
// Reads num_byte words from the byte RAM starting at start_addr and streams
// them out one bit per valid/ready handshake, prefetching the next word.
module ram_out_bit_serializer
  import ram_out_bit_serializer_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
  parameter int RAM_READ_LATENCY = DEF_RAM_READ_LATENCY,
  parameter bit LSB_FIRST        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH:0]   num_byte,
  output logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic                     bit_out,
  output logic                     bit_valid,
  input  logic                     bit_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int LAT_W = $clog2(DATA_WIDTH) + 1;

  state_t                 state;
  logic [LAT_W-1:0]       lat_cnt;
  logic [ADDRESS_WIDTH:0] num_lat;
  logic [ADDRESS_WIDTH:0] word_cnt;

  logic handshake;
  logic fetch_done;
  logic final_word;
  logic sr_load;
  logic sr_shift;
  logic sr_bit;
  logic sr_last;

  assign handshake  = bit_valid && bit_ready;
  assign fetch_done = (state == FETCH) && (lat_cnt == LAT_W'(RAM_READ_LATENCY));
  assign final_word = (word_cnt == num_lat);
  // The prefetched word is reloaded on the last bit of every non-final word
  assign sr_load    = fetch_done || ((state == SHIFT) && handshake && sr_last && !final_word);
  assign sr_shift   = (state == SHIFT) && handshake && !sr_last;
  assign bit_out    = bit_valid && sr_bit;

  bit_shift_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .din      (data),
    .bit_cur  (sr_bit),
    .last_bit (sr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lat_cnt   <= '0;
      num_lat   <= '0;
      word_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_byte == '0) begin
              done <= 1'b1;
            end else begin
              num_lat <= num_byte;
              addr    <= start_addr;
              busy    <= 1'b1;
              lat_cnt <= '0;
              state   <= FETCH;
            end
          end
        end
        FETCH: begin
          if (fetch_done) begin
            bit_valid <= 1'b1;
            addr      <= addr + ADDRESS_WIDTH'(1);
            word_cnt  <= (ADDRESS_WIDTH + 1)'(1);
            state     <= SHIFT;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        SHIFT: begin
          if (handshake && sr_last) begin
            addr <= addr + ADDRESS_WIDTH'(1);
            if (final_word) begin
              bit_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              word_cnt <= word_cnt + (ADDRESS_WIDTH + 1)'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
